nreno_ack_engine: RTL

- Pipelined NewReno incoming-ACK processor. It is the per-ACK counterpart of the NewReno timeout handler.
- Consumes one cumulative ACK event plus the flow's packed user context. Returns the updated context, the window size and a retransmit request.
- Covers duplicate-ACK counting, fast retransmit, recovery with partial/full ACKs, slow start and congestion avoidance.
- Sits between the ACK-event dispatcher and the flow-context writeback. Two-stage valid/ready pipeline, one event per cycle.

---
 rtl/nreno_ack_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/nreno_ack_engine.sv
// NewReno per-ACK processor: S1 classifies the ACK against the flow context,
// S2 registers the updated context, window and retransmit request.
module nreno_ack_engine #(
  parameter int unsigned SEQ_W      = 32,
  parameter int unsigned WIN_W      = 9,
  parameter int unsigned CTX_W      = 2*SEQ_W+5*WIN_W+2,
  parameter int unsigned DUP_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEQ_W-1:0] ack_seq_in,
  input  logic [SEQ_W-1:0] next_new_in,
  input  logic [CTX_W-1:0] user_cntxt_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTX_W-1:0] user_cntxt_out,
  output logic [WIN_W-1:0] wnd_size_out,
  output logic             mark_rtx,
  output logic [SEQ_W-1:0] rtx_start,
  output logic [SEQ_W-1:0] rtx_end,
  output logic             reset_timer
);

  // Context fields are packed from the LSB upward; the WIN_W bits left above
  // prev_hgst_ack are reserved and travel through untouched.
  localparam int unsigned CWND_LSB  = 0;
  localparam int unsigned DUP_LSB   = WIN_W;
  localparam int unsigned SS_LSB    = 2*WIN_W;
  localparam int unsigned WINC_LSB  = 3*WIN_W;
  localparam int unsigned TMO_BIT   = 4*WIN_W;
  localparam int unsigned REC_LSB   = 4*WIN_W+1;
  localparam int unsigned INREC_BIT = REC_LSB+SEQ_W;
  localparam int unsigned PREV_LSB  = INREC_BIT+1;

  localparam logic [WIN_W-1:0] WMAX = '1;
  localparam logic [WIN_W-1:0] WONE = WIN_W'(1);
  localparam logic [WIN_W-1:0] WTWO = WIN_W'(2);
  localparam logic [WIN_W-1:0] DTH  = WIN_W'(DUP_THRESH);

  typedef enum logic [1:0] {CLS_STALE, CLS_DUP, CLS_NEW} cls_e;

  logic s1_adv, s2_adv;
  logic s1_v_q, s2_v_q;

  logic [SEQ_W-1:0] s1_ack_q, s1_nn_q, s1_d_q;
  logic [CTX_W-1:0] s1_ctx_q;
  cls_e             s1_cls_q;

  logic [CTX_W-1:0] s2_ctx_q, s2_ctx_d;
  logic             s2_mark_q, s2_mark_d;
  logic             s2_rt_q, s2_rt_d;
  logic [SEQ_W-1:0] s2_rtxs_q, s2_rtxe_q;

  logic [SEQ_W-1:0] d_s0, o_s0;
  cls_e             cls_s0;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv && !rst;

  always_comb begin
    d_s0   = ack_seq_in  - user_cntxt_in[PREV_LSB +: SEQ_W];
    o_s0   = next_new_in - user_cntxt_in[PREV_LSB +: SEQ_W];
    cls_s0 = CLS_STALE;
    if (d_s0 == '0) begin
      if (o_s0 != '0) cls_s0 = CLS_DUP;
    end else if (d_s0 <= o_s0) begin
      cls_s0 = CLS_NEW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_ack_q <= '0;
      s1_nn_q  <= '0;
      s1_d_q   <= '0;
      s1_ctx_q <= '0;
      s1_cls_q <= CLS_STALE;
    end else if (s1_adv) begin
      s1_v_q   <= in_valid;
      s1_ack_q <= ack_seq_in;
      s1_nn_q  <= next_new_in;
      s1_d_q   <= d_s0;
      s1_ctx_q <= user_cntxt_in;
      s1_cls_q <= cls_s0;
    end
  end

  logic [WIN_W-1:0] cwnd, dup, ss, winc, a, dup_inc, half, ss_fr;
  logic [WIN_W-1:0] n_cwnd, n_dup, n_ss, n_winc;
  logic [WIN_W:0]   sum_fr, sum_ss, t_ca, part;
  logic [SEQ_W-1:0] rec, fdist, n_rec, n_prev;
  logic             inrec, n_inrec, n_tmo;

  always_comb begin
    cwnd   = s1_ctx_q[CWND_LSB +: WIN_W];
    if (cwnd == '0) cwnd = WONE;
    dup    = s1_ctx_q[DUP_LSB +: WIN_W];
    ss     = s1_ctx_q[SS_LSB +: WIN_W];
    winc   = s1_ctx_q[WINC_LSB +: WIN_W];
    rec    = s1_ctx_q[REC_LSB +: SEQ_W];
    inrec  = s1_ctx_q[INREC_BIT];
    a      = (|(s1_d_q >> WIN_W)) ? WMAX : s1_d_q[WIN_W-1:0];
    dup_inc = (dup == WMAX) ? WMAX : dup + WONE;
    half   = cwnd >> 1;
    ss_fr  = (half < WTWO) ? WTWO : half;
    sum_fr = {1'b0, ss_fr} + (WIN_W+1)'(3);
    sum_ss = {1'b0, cwnd} + {1'b0, a};
    t_ca   = {1'b0, winc} + {1'b0, a};
    part   = {1'b0, cwnd} + (WIN_W+1)'(1);
    fdist  = s1_ack_q - SEQ_W'(1) - rec;

    n_cwnd  = cwnd;
    n_dup   = dup;
    n_ss    = ss;
    n_winc  = winc;
    n_tmo   = s1_ctx_q[TMO_BIT];
    n_rec   = rec;
    n_inrec = inrec;
    n_prev  = s1_ctx_q[PREV_LSB +: SEQ_W];
    s2_mark_d = 1'b0;
    s2_rt_d   = 1'b0;

    case (s1_cls_q)
      CLS_DUP: begin
        n_dup = dup_inc;
        if (dup_inc == DTH && !inrec) begin
          n_ss      = ss_fr;
          n_cwnd    = sum_fr[WIN_W] ? WMAX : sum_fr[WIN_W-1:0];
          n_inrec   = 1'b1;
          n_rec     = s1_nn_q - SEQ_W'(1);
          s2_mark_d = 1'b1;
        end else if (inrec && dup_inc > DTH) begin
          n_cwnd = (cwnd == WMAX) ? WMAX : cwnd + WONE;
        end
      end
      CLS_NEW: begin
        n_dup   = '0;
        n_tmo   = 1'b0;
        n_prev  = s1_ack_q;
        s2_rt_d = 1'b1;
        if (inrec && !fdist[SEQ_W-1]) begin
          n_cwnd  = (ss == '0) ? WONE : ss;
          n_inrec = 1'b0;
        end else if (inrec) begin
          s2_mark_d = 1'b1;
          // cwnd+1 > a keeps the difference at least 1
          n_cwnd = (part > {1'b0, a}) ? WIN_W'(part - {1'b0, a}) : WONE;
        end else if (cwnd < ss) begin
          n_cwnd = sum_ss[WIN_W] ? WMAX : sum_ss[WIN_W-1:0];
        end else if (t_ca >= {1'b0, cwnd}) begin
          n_cwnd = (cwnd == WMAX) ? WMAX : cwnd + WONE;
          n_winc = (t_ca - {1'b0, cwnd} > {1'b0, WMAX}) ? WMAX
                                                        : WIN_W'(t_ca - {1'b0, cwnd});
        end else begin
          n_winc = t_ca[WIN_W-1:0];
        end
      end
      default: ;
    endcase

    s2_ctx_d = s1_ctx_q;
    s2_ctx_d[CWND_LSB +: WIN_W] = n_cwnd;
    s2_ctx_d[DUP_LSB +: WIN_W]  = n_dup;
    s2_ctx_d[SS_LSB +: WIN_W]   = n_ss;
    s2_ctx_d[WINC_LSB +: WIN_W] = n_winc;
    s2_ctx_d[TMO_BIT]           = n_tmo;
    s2_ctx_d[REC_LSB +: SEQ_W]  = n_rec;
    s2_ctx_d[INREC_BIT]         = n_inrec;
    s2_ctx_d[PREV_LSB +: SEQ_W] = n_prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_ctx_q  <= '0;
      s2_mark_q <= 1'b0;
      s2_rt_q   <= 1'b0;
      s2_rtxs_q <= '0;
      s2_rtxe_q <= '0;
    end else if (s2_adv) begin
      s2_v_q    <= s1_v_q;
      s2_ctx_q  <= s2_ctx_d;
      s2_mark_q <= s2_mark_d;
      s2_rt_q   <= s2_rt_d;
      s2_rtxs_q <= s1_ack_q;
      s2_rtxe_q <= s1_ack_q + SEQ_W'(1);
    end
  end

  assign out_valid      = s2_v_q;
  assign user_cntxt_out = s2_ctx_q;
  assign wnd_size_out   = s2_ctx_q[CWND_LSB +: WIN_W];
  assign mark_rtx       = s2_v_q && s2_mark_q;
  assign reset_timer    = s2_v_q && s2_rt_q;
  assign rtx_start      = s2_rtxs_q;
  assign rtx_end        = s2_rtxe_q;

endmodule
